uart_rx: RTL and testbench

8N1 UART receiver. It is the receive-side counterpart of uart_tx and uses the same bit timing (27 MHz clock, 115200 baud, clk_divide = 234). It synchronises the asynchronous serial input, rejects false starts, samples each bit at mid-bit, and presents each received byte with a one-cycle valid strobe. It sits between the board RX pin and byte-level consumers, and pairs with uart_tx in loopback tests.

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises RX, rejects false starts, samples each bit at
// mid-bit and emits one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int clk_divide = 234
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] RX_DATA_OUT,
  output logic       RX_VALID,
  output logic       RX_FRAME_ERR,
  output logic       RX_ACTIVE
);

  localparam int half_bit = clk_divide / 2;
  localparam int cnt_w    = $clog2(clk_divide);

  localparam logic [cnt_w-1:0] half_last = cnt_w'(half_bit - 1);
  localparam logic [cnt_w-1:0] bit_last  = cnt_w'(clk_divide - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rx_s;
  logic [cnt_w-1:0] cycle_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             half_done;
  logic             bit_done;
  logic             data_sample;
  logic             frame_ok;
  logic             frame_bad;
  logic             active;

  // Flops reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep rx_s one full cycle behind rx_meta;
      // blocking ones here would collapse the two flops into one.
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  assign half_done = (cycle_cnt == half_last);
  assign bit_done  = (cycle_cnt == bit_last);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (half_done) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        // Leaving at the stop-bit mid-sample lets a zero-gap next start be seen.
        if (bit_done) state_next = rx_s ? IDLE : BREAK_WAIT;
      end
      BREAK_WAIT: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    active      = 1'b0;
    data_sample = 1'b0;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      START: active = 1'b1;
      DATA: begin
        active      = 1'b1;
        data_sample = bit_done;
      end
      STOP: begin
        active    = 1'b1;
        frame_ok  = bit_done && rx_s;
        frame_bad = bit_done && !rx_s;
      end
      default: active = 1'b0;
    endcase
  end

  assign RX_ACTIVE = active;

  // Counter restarts on every state change and at each data-bit sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt <= '0;
    end else if ((state_next != state) || bit_done ||
                 (state == IDLE) || (state == BREAK_WAIT)) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_idx <= 3'd0;
    end else if ((state_next == DATA) && (state != DATA)) begin
      bit_idx <= 3'd0;
    end else if (data_sample) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // NOTE: shift_reg is an ordinary register, not a memory, so it is cheap to reset
  // and doing so keeps aborted frames from leaking stale bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_reg <= 8'h00;
    end else if (data_sample) begin
      shift_reg[bit_idx] <= rx_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RX_DATA_OUT  <= 8'h00;
      RX_VALID     <= 1'b0;
      RX_FRAME_ERR <= 1'b0;
    end else begin
      RX_VALID     <= frame_ok;
      RX_FRAME_ERR <= frame_bad;
      if (frame_ok) RX_DATA_OUT <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: single frame with latency, back-to-back frames,
// false start, break, mid-frame reset and baud tolerance.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_T   = 234;
  localparam int LAT_EXP = 2 + 117 + 8 * 234 + 234 + 1;

  logic       CLK;
  logic       RST;
  logic       RX;
  logic [7:0] RX_DATA_OUT;
  logic       RX_VALID;
  logic       RX_FRAME_ERR;
  logic       RX_ACTIVE;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  int         fall_cyc;
  int         valid_cyc;
  int         err_cnt;
  int         act_cnt;
  int         proto_err = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] rx_q[$];

  uart_rx #(.clk_divide(BIT_T)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX          (RX),
    .RX_DATA_OUT (RX_DATA_OUT),
    .RX_VALID    (RX_VALID),
    .RX_FRAME_ERR(RX_FRAME_ERR),
    .RX_ACTIVE   (RX_ACTIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      prev_pulse = 1'b0;
    end else begin
      if (RX_VALID) begin
        rx_q.push_back(RX_DATA_OUT);
        valid_cyc = cyc;
      end
      if (RX_FRAME_ERR) err_cnt++;
      if (RX_ACTIVE) act_cnt++;
      if (RX_VALID && RX_FRAME_ERR) proto_err++;
      if ((RX_VALID || RX_FRAME_ERR) && prev_pulse) proto_err++;
      prev_pulse = RX_VALID || RX_FRAME_ERR;
    end
  end

  initial begin
    repeat (80000) @(posedge CLK);
    $display("FAIL watchdog: run still going after 80000 cycles, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mon();
    rx_q.delete();
    err_cnt = 0;
    act_cnt = 0;
  endtask

  // Caller is at a falling edge; drives one frame, leaves RX at the stop level.
  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
    RX = 1'b0;
    fall_cyc = cyc;
    repeat (period) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (period) @(negedge CLK);
    end
    RX = stop_bit;
    repeat (period) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RX  = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({RX_DATA_OUT, RX_VALID, RX_FRAME_ERR, RX_ACTIVE} !== 11'h000) begin
      failures++;
      $display("FAIL reset_state: got data=%h v=%b e=%b a=%b, required 00 0 0 0",
               RX_DATA_OUT, RX_VALID, RX_FRAME_ERR, RX_ACTIVE);
    end
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_single_frame();
    int lat;
    clear_mon();
    send_frame(8'h41, BIT_T, 1'b1);
    repeat (300) @(negedge CLK);
    checks++;
    if (rx_q.size() !== 1) begin
      failures++;
      $display("FAIL single_count: got %0d valid pulses, required 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h41) begin
        failures++;
        $display("FAIL single_data: got %h, required 41", rx_q[0]);
      end
      lat = valid_cyc - fall_cyc;
      checks++;
      if (lat < LAT_EXP - 1 || lat > LAT_EXP + 1) begin
        failures++;
        $display("FAIL single_latency: got %0d cycles, required %0d +-1", lat, LAT_EXP);
      end
    end
    checks++;
    if (err_cnt !== 0) begin
      failures++;
      $display("FAIL single_ferr: got %0d error pulses, required 0", err_cnt);
    end
    checks++;
    if (RX_DATA_OUT !== 8'h41) begin
      failures++;
      $display("FAIL single_hold: got %h, required 41", RX_DATA_OUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[4];
    exp_b = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
    clear_mon();
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], BIT_T, 1'b1);
    repeat (300) @(negedge CLK);
    checks++;
    if (rx_q.size() !== 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d valid pulses, required 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got %h, required %h", i, rx_q[i], exp_b[i]);
        end
      end
    end
    checks++;
    if (err_cnt !== 0) begin
      failures++;
      $display("FAIL b2b_ferr: got %0d error pulses, required 0", err_cnt);
    end
  endtask

  task automatic test_false_start();
    clear_mon();
    RX = 1'b0;
    repeat (60) @(negedge CLK);
    RX = 1'b1;
    repeat (200) @(negedge CLK);
    checks++;
    if (rx_q.size() !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL glitch_pulses: got valid=%0d err=%0d, required 0 0", rx_q.size(), err_cnt);
    end
    checks++;
    if (act_cnt < 116 || act_cnt > 118) begin
      failures++;
      $display("FAIL glitch_active: got %0d active cycles, required 117 +-1", act_cnt);
    end
    checks++;
    if (RX_ACTIVE !== 1'b0) begin
      failures++;
      $display("FAIL glitch_idle: got active=%b, required 0", RX_ACTIVE);
    end
    clear_mon();
    send_frame(8'h3C, BIT_T, 1'b1);
    repeat (300) @(negedge CLK);
    checks++;
    if (rx_q.size() !== 1 || RX_DATA_OUT !== 8'h3C) begin
      failures++;
      $display("FAIL glitch_next: got count=%0d data=%h, required 1 3c", rx_q.size(), RX_DATA_OUT);
    end
  endtask

  task automatic test_break();
    clear_mon();
    send_frame(8'h55, BIT_T, 1'b0);
    repeat (5000) @(negedge CLK);
    checks++;
    if (err_cnt !== 1) begin
      failures++;
      $display("FAIL break_ferr: got %0d error pulses, required 1", err_cnt);
    end
    checks++;
    if (rx_q.size() !== 0) begin
      failures++;
      $display("FAIL break_valid: got %0d valid pulses, required 0", rx_q.size());
    end
    checks++;
    if (RX_DATA_OUT !== 8'h3C) begin
      failures++;
      $display("FAIL break_hold: got %h, required 3c", RX_DATA_OUT);
    end
    checks++;
    if (RX_ACTIVE !== 1'b0) begin
      failures++;
      $display("FAIL break_active: got %b, required 0", RX_ACTIVE);
    end
    RX = 1'b1;
    repeat (300) @(negedge CLK);
    clear_mon();
    send_frame(8'h12, BIT_T, 1'b1);
    repeat (300) @(negedge CLK);
    checks++;
    if (rx_q.size() !== 1 || RX_DATA_OUT !== 8'h12 || err_cnt !== 0) begin
      failures++;
      $display("FAIL break_next: got count=%0d data=%h err=%0d, required 1 12 0",
               rx_q.size(), RX_DATA_OUT, err_cnt);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] b;
    b = 8'h81;
    clear_mon();
    RX = 1'b0;
    repeat (BIT_T) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      repeat (BIT_T) @(negedge CLK);
    end
    RX = b[4];
    repeat (BIT_T / 2) @(negedge CLK);
    RST = 1'b1;
    RX  = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if ({RX_DATA_OUT, RX_VALID, RX_FRAME_ERR, RX_ACTIVE} !== 11'h000) begin
      failures++;
      $display("FAIL rst_outputs: got data=%h v=%b e=%b a=%b, required 00 0 0 0",
               RX_DATA_OUT, RX_VALID, RX_FRAME_ERR, RX_ACTIVE);
    end
    repeat (2500) @(negedge CLK);
    checks++;
    if (rx_q.size() !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL rst_no_pulse: got valid=%0d err=%0d, required 0 0", rx_q.size(), err_cnt);
    end
    send_frame(8'h7E, BIT_T, 1'b1);
    repeat (300) @(negedge CLK);
    checks++;
    if (rx_q.size() !== 1 || RX_DATA_OUT !== 8'h7E) begin
      failures++;
      $display("FAIL rst_next: got count=%0d data=%h, required 1 7e", rx_q.size(), RX_DATA_OUT);
    end
  endtask

  task automatic test_baud_tolerance();
    int periods[2];
    periods = '{225, 243};
    for (int p = 0; p < 2; p++) begin
      clear_mon();
      send_frame(8'hC3, periods[p], 1'b1);
      repeat (300) @(negedge CLK);
      checks++;
      if (rx_q.size() !== 1 || RX_DATA_OUT !== 8'hC3 || err_cnt !== 0) begin
        failures++;
        $display("FAIL baud_%0d: got count=%0d data=%h err=%0d, required 1 c3 0",
                 periods[p], rx_q.size(), RX_DATA_OUT, err_cnt);
      end
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (proto_err !== 0) begin
      failures++;
      $display("FAIL strobe_rules: got %0d overlapping/long pulses, required 0", proto_err);
    end
  endtask

  initial begin
    RST = 1'b1;
    RX  = 1'b1;
    err_cnt = 0;
    act_cnt = 0;
    @(negedge CLK);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_false_start();
    test_break();
    test_mid_frame_reset();
    test_baud_tolerance();
    test_strobe_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
